// File: rtl/bus_dma.sv
`default_nettype none
// ============================================================================
//  Module      : bus_dma
//  Description : Word-copy DMA engine on a toggle-handshake bus (read word,
//                write word, repeat) with early abort support.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_dma #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] src,
    input  logic [ADDR_WIDTH-1:0] dst,
    input  logic [ADDR_WIDTH-1:0] len,
    output logic                  busy,
    output logic                  done_pulse,
    output logic                  aborted,
    output logic [ADDR_WIDTH-1:0] words_done,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [1:0]            bus_cmd,
    output logic                  bus_run,
    output logic [15:0]           bus_wr_data,
    input  logic [15:0]           bus_rd_data,
    input  logic                  bus_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_WR_WAIT = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;

    localparam logic [1:0] C_CMD_NOP = 2'b00;
    localparam logic [1:0] C_CMD_RD  = 2'b01;
    localparam logic [1:0] C_CMD_WR  = 2'b10;

    localparam logic [ADDR_WIDTH-1:0] C_ONE = ADDR_WIDTH'(1);

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH-1:0] r_remain;
    logic [15:0]           r_data;
    logic                  r_abort_pend;
    logic                  r_busy;
    logic                  r_done_pulse;
    logic                  r_aborted;
    logic [ADDR_WIDTH-1:0] r_words_done;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [1:0]            r_bus_cmd;
    logic                  r_bus_run;
    logic [15:0]           r_bus_wr_data;

    // The bus is ours to use only when no request is outstanding.
    logic w_bus_idle;
    assign w_bus_idle = (r_bus_run == bus_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_src         <= '0;
            r_dst         <= '0;
            r_remain      <= '0;
            r_data        <= '0;
            r_abort_pend  <= 1'b0;
            r_busy        <= 1'b0;
            r_done_pulse  <= 1'b0;
            r_aborted     <= 1'b0;
            r_words_done  <= '0;
            r_bus_addr    <= '0;
            r_bus_cmd     <= C_CMD_NOP;
            r_bus_run     <= 1'b0;
            r_bus_wr_data <= '0;
        end else begin
            r_done_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src        <= src;
                        r_dst        <= dst;
                        r_remain     <= len;
                        r_words_done <= '0;
                        r_aborted    <= 1'b0;
                        r_abort_pend <= 1'b0;
                        r_busy       <= 1'b1;
                        if (len == '0) begin
                            r_state      <= S_FINISH;
                            r_done_pulse <= 1'b1;
                            r_bus_cmd    <= C_CMD_NOP;
                        end else begin
                            r_state <= S_RD_REQ;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (abort) begin
                        r_state      <= S_FINISH;
                        r_done_pulse <= 1'b1;
                        r_bus_cmd    <= C_CMD_NOP;
                        r_aborted    <= 1'b1;
                    end else if (w_bus_idle) begin
                        r_bus_addr <= r_src;
                        r_bus_cmd  <= C_CMD_RD;
                        r_bus_run  <= ~r_bus_run;
                        r_state    <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (w_bus_idle) begin
                        r_data <= bus_rd_data;
                        if (abort || r_abort_pend) begin
                            r_state      <= S_FINISH;
                            r_done_pulse <= 1'b1;
                            r_bus_cmd    <= C_CMD_NOP;
                            r_aborted    <= 1'b1;
                        end else begin
                            r_state <= S_WR_REQ;
                        end
                    end else if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                end
                S_WR_REQ: begin
                    if (abort) begin
                        r_state      <= S_FINISH;
                        r_done_pulse <= 1'b1;
                        r_bus_cmd    <= C_CMD_NOP;
                        r_aborted    <= 1'b1;
                    end else if (w_bus_idle) begin
                        r_bus_addr    <= r_dst;
                        r_bus_wr_data <= r_data;
                        r_bus_cmd     <= C_CMD_WR;
                        r_bus_run     <= ~r_bus_run;
                        r_state       <= S_WR_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    if (w_bus_idle) begin
                        r_src        <= r_src + C_ONE;
                        r_dst        <= r_dst + C_ONE;
                        r_words_done <= r_words_done + C_ONE;
                        r_remain     <= r_remain - C_ONE;
                        // A copy whose last word just landed is complete, abort or not.
                        if (r_remain == C_ONE) begin
                            r_state      <= S_FINISH;
                            r_done_pulse <= 1'b1;
                            r_bus_cmd    <= C_CMD_NOP;
                        end else if (abort || r_abort_pend) begin
                            r_state      <= S_FINISH;
                            r_done_pulse <= 1'b1;
                            r_bus_cmd    <= C_CMD_NOP;
                            r_aborted    <= 1'b1;
                        end else begin
                            r_state <= S_RD_REQ;
                        end
                    end else if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done_pulse  = r_done_pulse;
    assign aborted     = r_aborted;
    assign words_done  = r_words_done;
    assign bus_addr    = r_bus_addr;
    assign bus_cmd     = r_bus_cmd;
    assign bus_run     = r_bus_run;
    assign bus_wr_data = r_bus_wr_data;

endmodule
`default_nettype wire
